// File: rtl/icg_pkg.sv
// rtl/icg_pkg.sv - shared clock-gate control package
// State encoding, default counter widths and the state-to-output decode.
package icg_pkg;

  localparam int IDLE_W_DEF = 8;
  localparam int WAKE_W_DEF = 4;
  localparam int STAT_W_DEF = 16;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_OFF   = 2'd2;
  localparam logic [1:0] ST_WAKE  = 2'd3;

  typedef struct packed {
    logic gate_en;
    logic ready;
    logic gated;
  } icg_out_t;

  // Outputs are a pure function of the state being entered.
  function automatic icg_out_t state_outputs(input logic [1:0] st);
    icg_out_t o;
    o.gate_en = (st != ST_OFF);
    o.ready   = (st == ST_RUN) || (st == ST_DRAIN);
    o.gated   = (st == ST_OFF);
    return o;
  endfunction

endpackage

// File: rtl/icg_sat_counter.sv
// rtl/icg_sat_counter.sv - saturating up-counter with synchronous clear
// Clear has priority over increment; the count holds at all-ones.
module icg_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/icg_enable_ctrl.sv
// rtl/icg_enable_ctrl.sv - idle-timeout clock-gate enable controller
// RUN -> DRAIN -> OFF -> WAKE -> RUN; all outputs registered from the next state.
module icg_enable_ctrl
  import icg_pkg::*;
#(
  parameter int IDLE_W = IDLE_W_DEF,
  parameter int WAKE_W = WAKE_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              req_i,
  input  logic              force_on_i,
  input  logic [IDLE_W-1:0] idle_limit_i,
  input  logic [WAKE_W-1:0] wake_delay_i,
  output logic              gate_en_o,
  output logic              ready_o,
  output logic              gated_o,
  output logic [STAT_W-1:0] gate_cnt_o
);

  localparam logic [WAKE_W-1:0] WAKE_ONE = WAKE_W'(1);
  localparam logic [IDLE_W:0]   IDLE_ONE = (IDLE_W+1)'(1);

  logic [1:0]        state_q, state_d;
  logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
  icg_out_t          out_q, out_d;

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_clr, idle_inc, gate_inc;
  logic              active;
  logic [IDLE_W:0]   idle_next;
  logic              limit_hit;

  assign active    = req_i | force_on_i;
  // One extra bit so a saturated idle_cnt still compares correctly.
  assign idle_next = {1'b0, idle_cnt} + IDLE_ONE;
  assign limit_hit = (idle_limit_i != '0) && (idle_next >= {1'b0, idle_limit_i});

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_clr   = 1'b1;
    idle_inc   = 1'b0;
    gate_inc   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!active && limit_hit) begin
          state_d = ST_DRAIN;
        end else if (!active) begin
          idle_clr = 1'b0;
          idle_inc = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (active) begin
          state_d = ST_RUN;
        end else begin
          state_d  = ST_OFF;
          gate_inc = 1'b1;
        end
      end
      ST_OFF: begin
        if (active) begin
          state_d    = ST_WAKE;
          wake_cnt_d = wake_delay_i;
        end
      end
      ST_WAKE: begin
        // Requests are deliberately ignored here; wake always completes.
        if (wake_cnt_q != '0) begin
          wake_cnt_d = wake_cnt_q - WAKE_ONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    out_d = state_outputs(state_d);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q    <= ST_RUN;
      wake_cnt_q <= '0;
      out_q      <= state_outputs(ST_RUN);
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      out_q      <= out_d;
    end
  end

  icg_sat_counter #(.W(IDLE_W)) u_idle_cnt (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .clr_i  (idle_clr),
    .inc_i  (idle_inc),
    .cnt_o  (idle_cnt)
  );

  icg_sat_counter #(.W(STAT_W)) u_gate_cnt (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .clr_i  (1'b0),
    .inc_i  (gate_inc),
    .cnt_o  (gate_cnt_o)
  );

  assign gate_en_o = out_q.gate_en;
  assign ready_o   = out_q.ready;
  assign gated_o   = out_q.gated;

endmodule

// File: tb/tb_icg_enable_ctrl.sv
// tb/tb_icg_enable_ctrl.sv - self-checking bench for icg_enable_ctrl
// Directed scenarios with literal expectations, then randomized traffic against a mode model.
module tb_icg_enable_ctrl;

  localparam int IDLE_W = 8;
  localparam int WAKE_W = 4;
  localparam int STAT_W = 2;
  localparam int CNT_MAX = (1 << STAT_W) - 1;

  localparam int M_RUN = 0, M_DRAIN = 1, M_OFF = 2, M_WAKE = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              force_on = 1'b0;
  logic [IDLE_W-1:0] idle_limit = '0;
  logic [WAKE_W-1:0] wake_delay = '0;
  logic              gate_en, ready, gated;
  logic [STAT_W-1:0] gate_cnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int m_mode = M_RUN;
  int m_idle = 0;
  int m_wake = 0;
  int m_events = 0;

  always #5 clk = ~clk;

  icg_enable_ctrl #(.IDLE_W(IDLE_W), .WAKE_W(WAKE_W), .STAT_W(STAT_W)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .req_i        (req),
    .force_on_i   (force_on),
    .idle_limit_i (idle_limit),
    .wake_delay_i (wake_delay),
    .gate_en_o    (gate_en),
    .ready_o      (ready),
    .gated_o      (gated),
    .gate_cnt_o   (gate_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: counts consecutive idle cycles with plain integers.
  always @(posedge clk) begin
    automatic int mode = m_mode;
    automatic int idle = m_idle;
    automatic int wk = m_wake;
    automatic int ev = m_events;
    automatic bit act = req || force_on;
    if (!rst_n) begin
      mode = M_RUN; idle = 0; wk = 0; ev = 0;
    end else if (mode == M_RUN) begin
      if (act) idle = 0;
      else if (idle_limit != 0 && idle + 1 >= int'(idle_limit)) begin
        mode = M_DRAIN; idle = 0;
      end else idle = idle + 1;
    end else if (mode == M_DRAIN) begin
      if (act) mode = M_RUN;
      else begin
        mode = M_OFF;
        ev = (ev < CNT_MAX) ? ev + 1 : CNT_MAX;
      end
    end else if (mode == M_OFF) begin
      if (act) begin mode = M_WAKE; wk = int'(wake_delay); end
    end else begin
      if (wk > 0) wk = wk - 1;
      else begin mode = M_RUN; idle = 0; end
    end
    m_mode <= mode;
    m_idle <= idle;
    m_wake <= wk;
    m_events <= ev;
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_gate_en", int'(gate_en), int'(m_mode != M_OFF));
      chk("model_ready", int'(ready), int'(m_mode == M_RUN || m_mode == M_DRAIN));
      chk("model_gated", int'(gated), int'(m_mode == M_OFF));
      chk("model_gate_cnt", int'(gate_cnt), m_events);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_out(input string name, input int ge, input int rd, input int gd, input int cnt);
    chk({name, "_gate_en"}, int'(gate_en), ge);
    chk({name, "_ready"}, int'(ready), rd);
    chk({name, "_gated"}, int'(gated), gd);
    chk({name, "_gate_cnt"}, int'(gate_cnt), cnt);
  endtask

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    step(1);
    check_en = 1'b1;
    chk_out("reset", 1, 1, 0, 0);

    // Limit 4: four RUN cycles, DRAIN, then OFF.
    rst_n = 1'b1; idle_limit = 8'd4; req = 1'b0;
    step(3);
    chk_out("idle3", 1, 1, 0, 0);
    step(1);
    chk_out("drain", 1, 1, 0, 0);
    step(1);
    chk_out("off1", 0, 0, 1, 1);

    // Wake with delay 3: ready five edges after req.
    wake_delay = 4'd3; req = 1'b1;
    step(1);
    chk_out("wake_first", 1, 0, 0, 1);
    step(3);
    chk_out("wake_last", 1, 0, 0, 1);
    step(1);
    chk_out("ready_after_wake", 1, 1, 0, 1);
    req = 1'b0;
    step(5);
    chk_out("regate", 0, 0, 1, 2);

    // Request on the limit cycle wins; request during DRAIN returns to RUN.
    wake_delay = 4'd0; req = 1'b1;
    step(2);
    chk_out("rewake", 1, 1, 0, 2);
    req = 1'b0; step(3);
    req = 1'b1; step(1);
    chk_out("req_on_limit", 1, 1, 0, 2);
    req = 1'b0; step(3);
    chk_out("idle_restart", 1, 1, 0, 2);
    step(1);
    chk_out("drain2", 1, 1, 0, 2);
    req = 1'b1; step(1);
    chk_out("drain_abort", 1, 1, 0, 2);

    // Limit 0 never gates.
    req = 1'b0; idle_limit = 8'd0;
    step(300);
    chk_out("limit0", 1, 1, 0, 2);
    idle_limit = 8'd1;
    step(2);
    chk_out("limit1_off", 0, 0, 1, 3);
    force_on = 1'b1;
    step(1);
    chk_out("force_wake", 1, 0, 0, 3);
    step(11);
    chk_out("force_hold", 1, 1, 0, 3);
    force_on = 1'b0;

    // Two more gating events: counter stays saturated.
    for (int i = 0; i < 2; i++) begin
      req = 1'b0; step(2);
      req = 1'b1; step(2);
    end
    req = 1'b0; step(2);
    chk_out("saturate", 0, 0, 1, 3);

    // Reset mid-WAKE and in OFF.
    wake_delay = 4'd7; req = 1'b1;
    step(3);
    chk_out("mid_wake", 1, 0, 0, 3);
    rst_n = 1'b0; step(1);
    chk_out("reset_wake", 1, 1, 0, 0);
    rst_n = 1'b1; req = 1'b0; idle_limit = 8'd1;
    step(2);
    chk_out("pre_reset_off", 0, 0, 1, 1);
    rst_n = 1'b0; step(1);
    chk_out("reset_off", 1, 1, 0, 0);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if (c % 60 == 0) idle_limit = 8'($urandom_range(0, 6));
      req = ($urandom_range(0, 99) < 30);
      force_on = ($urandom_range(0, 99) < 4);
      wake_delay = 4'($urandom_range(0, 4));
      rst_n = !($urandom_range(0, 299) == 0);
      step(1);
    end

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
